// File: rtl/write_once_reg_reader.sv
// Read-side responder for a bank of write-once protected registers.
// Accepts one read per request handshake, snapshots the addressed register
// (bit 0 replaced by its lock status) and holds it until the consumer takes it.

// Per-register formatter: the returned word carries the lock bit in bit 0.
module write_once_reg_lane #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] reg_data,
  input  logic              reg_lock,
  output logic [DATA_W-1:0] word
);
  // Bit 0 of the stored data is overlaid by the lock status.
  logic unused_bit0;
  assign unused_bit0 = reg_data[0];
  assign word        = {reg_data[DATA_W-1:1], reg_lock};
endmodule

module write_once_reg_reader #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                       Clk,
  input  logic                       ip_resetn,
  input  logic                       rd_req_valid,
  output logic                       rd_req_ready,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic [NUM_REGS*DATA_W-1:0] reg_data_flat,
  input  logic [NUM_REGS-1:0]        reg_lock,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_locked,
  output logic                       rsp_err,
  output logic [15:0]                rd_count
);

  typedef enum logic [1:0] {IDLE, SAMPLE, RESP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              locked;
    logic              err;
  } rsp_t;

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  state_t                           state_q, state_d;
  logic   [ADDR_W-1:0]              addr_q;
  rsp_t                             rsp_q, rsp_d;
  logic   [NUM_REGS-1:0][DATA_W-1:0] lane_word;
  logic   [DATA_W-1:0]              sel_word;
  logic                             sel_lock;
  logic                             accept, capture, done;

  // One formatter per register in the bank.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_lane
    write_once_reg_lane #(.DATA_W(DATA_W)) u_lane (
      .reg_data (reg_data_flat[i*DATA_W +: DATA_W]),
      .reg_lock (reg_lock[i]),
      .word     (lane_word[i])
    );
  end

  // Handshake qualifiers; ready depends on state only.
  assign rd_req_ready = (state_q == IDLE);
  assign accept       = rd_req_ready && rd_req_valid;
  assign capture      = (state_q == SAMPLE);
  assign done         = (state_q == RESP) && rsp_ready;

  // Address decode: explicit compare loop avoids indexing past the bank
  // when NUM_REGS is not a power of two.
  always_comb begin
    sel_word = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        sel_word = lane_word[i];
        sel_lock = reg_lock[i];
      end
    end
  end

  // Response snapshot contents; out-of-range reads return zeros plus err.
  always_comb begin
    rsp_d = '0;
    if ({1'b0, addr_q} < NUM_REGS_W) begin
      rsp_d.data   = sel_word;
      rsp_d.locked = sel_lock;
    end else begin
      rsp_d.err    = 1'b1;
    end
  end

  // Next-state logic: IDLE -> SAMPLE -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_req_valid) state_d = SAMPLE;
      SAMPLE:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge ip_resetn) begin
    if (!ip_resetn) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Address capture on request handshake.
  always_ff @(posedge Clk or negedge ip_resetn) begin
    if (!ip_resetn)  addr_q <= '0;
    else if (accept) addr_q <= rd_addr;
  end

  // Snapshot is taken once in SAMPLE and frozen until the next read.
  always_ff @(posedge Clk or negedge ip_resetn) begin
    if (!ip_resetn)   rsp_q <= '0;
    else if (capture) rsp_q <= rsp_d;
  end

  // Response valid: set on capture, cleared on consumer handshake.
  always_ff @(posedge Clk or negedge ip_resetn) begin
    if (!ip_resetn)   rsp_valid <= 1'b0;
    else if (capture) rsp_valid <= 1'b1;
    else if (done)    rsp_valid <= 1'b0;
  end

  // Saturating count of completed good reads.
  always_ff @(posedge Clk or negedge ip_resetn) begin
    if (!ip_resetn)
      rd_count <= '0;
    else if (done && !rsp_q.err && rd_count != 16'hFFFF)
      rd_count <= rd_count + 16'd1;
  end

  assign rsp_data   = rsp_q.data;
  assign rsp_locked = rsp_q.locked;
  assign rsp_err    = rsp_q.err;

endmodule

// File: tb/tb_write_once_reg_reader.sv
// Directed bench for write_once_reg_reader (3-register bank, 2-bit address).
module tb_write_once_reg_reader;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 3;
  localparam int ADDR_W   = 2;

  logic                       Clk = 1'b0;
  logic                       ip_resetn;
  logic                       rd_req_valid;
  logic                       rd_req_ready;
  logic [ADDR_W-1:0]          rd_addr;
  logic [NUM_REGS*DATA_W-1:0] reg_data_flat;
  logic [NUM_REGS-1:0]        reg_lock;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_W-1:0]          rsp_data;
  logic                       rsp_locked;
  logic                       rsp_err;
  logic [15:0]                rd_count;

  int n_chk = 0;
  int n_err = 0;

  write_once_reg_reader #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .Clk           (Clk),
    .ip_resetn     (ip_resetn),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_addr       (rd_addr),
    .reg_data_flat (reg_data_flat),
    .reg_lock      (reg_lock),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_locked    (rsp_locked),
    .rsp_err       (rsp_err),
    .rd_count      (rd_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_reg(input int i, input logic [DATA_W-1:0] v);
    reg_data_flat[i*DATA_W +: DATA_W] = v;
  endtask

  // Single read with rsp_ready high; checks latency, snapshot and count.
  task automatic read_chk(input string tag, input logic [ADDR_W-1:0] a,
                          input logic [15:0] exp_data, input logic exp_lock,
                          input logic exp_err, input logic [15:0] exp_cnt);
    chk({tag, ".idle_rdy"}, 32'(rd_req_ready), 32'd1);
    rd_req_valid = 1'b1;
    rd_addr      = a;
    rsp_ready    = 1'b1;
    @(negedge Clk);
    chk({tag, ".smp_rdy"}, 32'(rd_req_ready), 32'd0);
    chk({tag, ".smp_vld"}, 32'(rsp_valid), 32'd0);
    rd_req_valid = 1'b0;
    @(negedge Clk);
    chk({tag, ".vld"},    32'(rsp_valid), 32'd1);
    chk({tag, ".data"},   32'(rsp_data), 32'(exp_data));
    chk({tag, ".locked"}, 32'(rsp_locked), 32'(exp_lock));
    chk({tag, ".err"},    32'(rsp_err), 32'(exp_err));
    @(negedge Clk);
    chk({tag, ".vld_clr"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".cnt"},     32'(rd_count), 32'(exp_cnt));
    chk({tag, ".data_hold"}, 32'(rsp_data), 32'(exp_data));
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, ".vld"},    32'(rsp_valid), 32'd0);
    chk({tag, ".data"},   32'(rsp_data), 32'd0);
    chk({tag, ".locked"}, 32'(rsp_locked), 32'd0);
    chk({tag, ".err"},    32'(rsp_err), 32'd0);
    chk({tag, ".cnt"},    32'(rd_count), 32'd0);
  endtask

  // No response may appear for several cycles after reset release.
  task automatic chk_quiet(input string tag);
    int seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      if (rsp_valid) seen++;
    end
    chk({tag, ".no_rsp"}, 32'(seen), 32'd0);
    chk({tag, ".rdy"}, 32'(rd_req_ready), 32'd1);
  endtask

  initial begin
    int n_rsp;
    ip_resetn     = 1'b0;
    rd_req_valid  = 1'b0;
    rd_addr       = '0;
    rsp_ready     = 1'b0;
    reg_data_flat = '0;
    reg_lock      = '0;

    // Reset state
    @(negedge Clk);
    @(negedge Clk);
    chk_zero_outs("reset");
    ip_resetn = 1'b1;
    @(negedge Clk);
    chk("reset.rdy", 32'(rd_req_ready), 32'd1);

    // 1: locked register, lock bit shows in bit 0
    set_reg(1, 16'hABCD);
    reg_lock[1] = 1'b1;
    read_chk("t1", 2'd1, 16'hABCD, 1'b1, 1'b0, 16'd1);

    // 2: unlocked register, data bit 0 replaced by lock=0
    set_reg(2, 16'h1235);
    reg_lock[2] = 1'b0;
    read_chk("t2", 2'd2, 16'h1234, 1'b0, 1'b0, 16'd2);

    // 3: out-of-range address
    read_chk("t3", 2'd3, 16'h0000, 1'b0, 1'b1, 16'd2);

    // 4: backpressure; snapshot must stay frozen while reg0 changes
    set_reg(0, 16'h0001);
    reg_lock[0]  = 1'b1;
    rd_req_valid = 1'b1;
    rd_addr      = 2'd0;
    rsp_ready    = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("t4.vld", 32'(rsp_valid), 32'd1);
    set_reg(0, 16'hFFFF);
    reg_lock[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("t4.data_frozen", 32'(rsp_data), 32'h0001);
      chk("t4.rdy_low", 32'(rd_req_ready), 32'd0);
    end
    chk("t4.vld_held", 32'(rsp_valid), 32'd1);
    rd_req_valid = 1'b0;
    rsp_ready    = 1'b1;
    @(negedge Clk);
    chk("t4.vld_clr", 32'(rsp_valid), 32'd0);
    chk("t4.cnt", 32'(rd_count), 32'd3);

    // 5: back-to-back reads, one per 3 cycles
    set_reg(1, 16'h5A5B);
    reg_lock[1]  = 1'b0;
    rd_req_valid = 1'b1;
    rd_addr      = 2'd1;
    rsp_ready    = 1'b1;
    n_rsp = 0;
    for (int k = 0; k < 30; k++) begin
      if (rsp_valid && rsp_ready) n_rsp++;
      @(negedge Clk);
    end
    rd_req_valid = 1'b0;
    chk("t5.n_rsp", 32'(n_rsp), 32'd10);
    chk("t5.cnt", 32'(rd_count), 32'd13);
    chk("t5.data", 32'(rsp_data), 32'h5A5A);

    // 6a: reset during SAMPLE
    rd_req_valid = 1'b1;
    rd_addr      = 2'd1;
    rsp_ready    = 1'b1;
    @(negedge Clk);
    rd_req_valid = 1'b0;
    ip_resetn    = 1'b0;
    #1;
    chk_zero_outs("t6a");
    @(negedge Clk);
    ip_resetn = 1'b1;
    chk_quiet("t6a");

    // 6b: reset during RESP
    rd_req_valid = 1'b1;
    rd_addr      = 2'd1;
    rsp_ready    = 1'b0;
    @(negedge Clk);
    rd_req_valid = 1'b0;
    @(negedge Clk);
    chk("t6b.vld", 32'(rsp_valid), 32'd1);
    ip_resetn = 1'b0;
    #1;
    chk_zero_outs("t6b");
    @(negedge Clk);
    ip_resetn = 1'b1;
    rsp_ready = 1'b1;
    chk_quiet("t6b");

    // 6c: counter saturation
    force dut.rd_count = 16'hFFFE;
    @(negedge Clk);
    release dut.rd_count;
    @(negedge Clk);
    chk("t6c.preset", 32'(rd_count), 32'hFFFE);
    set_reg(2, 16'h0F0F);
    reg_lock[2] = 1'b1;
    read_chk("t6c.r1", 2'd2, 16'h0F0F, 1'b1, 1'b0, 16'hFFFF);
    read_chk("t6c.r2", 2'd2, 16'h0F0F, 1'b1, 1'b0, 16'hFFFF);
    read_chk("t6c.r3", 2'd2, 16'h0F0F, 1'b1, 1'b0, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
